// File: rtl/reset_sequencer_if.sv
// Control/status bundle between a reset_sequencer and its supervisor.
// The supervisor drives ready/restart and observes the staged resets.
interface reset_sequencer_if #(
  parameter int STEPS = 4
);
  logic             ready_async;
  logic             restart;
  logic [STEPS-1:0] rst_out;
  logic             done;
  logic             timeout;

  modport master (
    output ready_async, restart,
    input  rst_out, done, timeout
  );

  modport slave (
    input  ready_async, restart,
    output rst_out, done, timeout
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: synchronizes ready_async, then drops rst_out bits one by one.
// Optional HOLD watchdog enabled by defining RESET_SEQUENCER_TIMEOUT_EN.
module reset_sequencer #(
  parameter int STEPS        = 4,
  parameter int DELAY        = 16,
  parameter int EXTRA_STAGES = 0,
  parameter int TIMEOUT      = 1024
) (
  input  logic               reset,
  input  logic               clk,
  reset_sequencer_if.slave   bus
);

  // The FSM state register is the final synchronizer stage, so the explicit
  // chain is one flop shorter; the FSM reacts on the edge ready_sync rises.
  localparam int SYNC_LEN = 1 + EXTRA_STAGES;
  localparam int CNT_W    = $clog2(DELAY + 1);
  localparam int IDX_W    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DONE
  } state_t;

  logic [SYNC_LEN-1:0] sync_q;
  logic                ready_sync;
  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [STEPS-1:0]    rst_q;
  logic                done_q;
  logic                abort;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.ready_async;
      for (int i = 1; i < SYNC_LEN; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ready_sync = sync_q[SYNC_LEN-1];
  assign abort      = !ready_sync || bus.restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          rst_q  <= '1;
          done_q <= 1'b0;
          if (ready_sync) begin
            state <= RUN;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
          end else if (cnt == CNT_W'(DELAY - 1)) begin
            // Releases go in index order, so shifting a zero in clears bit idx.
            rst_q <= rst_q << 1;
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == IDX_W'(STEPS - 1)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (abort) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '1;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= HOLD;
          cnt    <= '0;
          idx    <= '0;
          rst_q  <= '1;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.done    = done_q;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] tcnt;
  logic              timeout_q;

  // Counts only edges that start and stay in HOLD; leaving HOLD or a restart clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else if (state != HOLD || ready_sync || bus.restart) begin
      tcnt      <= '0;
      timeout_q <= 1'b0;
    end else if (tcnt != TCNT_W'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Random-stimulus bench for reset_sequencer: four configurations share one stimulus
// stream and are compared every cycle against a timeline model of the release schedule.
module tb_reset_sequencer;

  localparam int NDUT = 4;
  localparam int TO   = 8;
  localparam int HMAX = 8192;
  localparam int STEPS_P [NDUT] = '{4, 4, 1, 3};
  localparam int DELAY_P [NDUT] = '{16, 16, 1, 3};
  localparam int EXTRA_P [NDUT] = '{0, 2, 0, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready_async = 1'b0;
  logic restart = 1'b0;

  int total = 0;
  int bad = 0;

  // Model: whether each DUT is sequencing, cycles since its start edge, HOLD cycles.
  bit  running [NDUT];
  int  elapsed [NDUT];
  int  hold_cnt [NDUT];
  bit  hist [HMAX];
  int  edge_no = 0;
  int  reset_mark = 0;
  bit  rs_sampled;

  always #5 clk = ~clk;

  reset_sequencer_if #(.STEPS(4)) bus0 ();
  reset_sequencer_if #(.STEPS(4)) bus1 ();
  reset_sequencer_if #(.STEPS(1)) bus2 ();
  reset_sequencer_if #(.STEPS(3)) bus3 ();

  assign bus0.ready_async = ready_async;
  assign bus1.ready_async = ready_async;
  assign bus2.ready_async = ready_async;
  assign bus3.ready_async = ready_async;
  assign bus0.restart     = restart;
  assign bus1.restart     = restart;
  assign bus2.restart     = restart;
  assign bus3.restart     = restart;

  reset_sequencer #(.STEPS(4), .DELAY(16), .EXTRA_STAGES(0), .TIMEOUT(TO)) dut0 (
    .reset(reset), .clk(clk), .bus(bus0.slave));
  reset_sequencer #(.STEPS(4), .DELAY(16), .EXTRA_STAGES(2), .TIMEOUT(TO)) dut1 (
    .reset(reset), .clk(clk), .bus(bus1.slave));
  reset_sequencer #(.STEPS(1), .DELAY(1), .EXTRA_STAGES(0), .TIMEOUT(TO)) dut2 (
    .reset(reset), .clk(clk), .bus(bus2.slave));
  reset_sequencer #(.STEPS(3), .DELAY(3), .EXTRA_STAGES(1), .TIMEOUT(TO)) dut3 (
    .reset(reset), .clk(clk), .bus(bus3.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    reset_mark = edge_no;
    for (int d = 0; d < NDUT; d++) begin
      running[d]  = 1'b0;
      elapsed[d]  = 0;
      hold_cnt[d] = 0;
    end
  endtask

  // ready as seen by the DUT's FSM at this edge: sampled 1+EXTRA edges earlier,
  // and never from before the most recent reset.
  function automatic bit ready_seen(input int d);
    int src;
    src = edge_no - (1 + EXTRA_P[d]);
    return (src > reset_mark && src >= 0) ? hist[src] : 1'b0;
  endfunction

  task automatic model_edge();
    bit rv;
    edge_no++;
    hist[edge_no] = ready_async;
    rs_sampled    = restart;
    if (reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        rv = ready_seen(d);
        if (!running[d]) begin
          if (rv) begin
            running[d]  = 1'b1;
            elapsed[d]  = 0;
            hold_cnt[d] = 0;
          end else if (rs_sampled) begin
            hold_cnt[d] = 0;
          end else if (hold_cnt[d] < TO) begin
            hold_cnt[d]++;
          end
        end else if (!rv || rs_sampled) begin
          running[d] = 1'b0;
          elapsed[d] = 0;
        end else if (elapsed[d] < STEPS_P[d] * DELAY_P[d]) begin
          elapsed[d]++;
        end
      end
    end
  endtask

  task automatic compare_one(input int d, input logic [31:0] r, input logic dn, input logic tmo);
    int          rel;
    logic [31:0] er;
    logic        et;
    rel = running[d] ? elapsed[d] / DELAY_P[d] : 0;
    er  = ((32'd1 << STEPS_P[d]) - 32'd1) & ~((32'd1 << rel) - 32'd1);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    et = (hold_cnt[d] >= TO);
`else
    et = 1'b0;
`endif
    check($sformatf("dut%0d rst_out", d), r, er);
    check($sformatf("dut%0d done", d), 32'(dn), 32'(running[d] && rel == STEPS_P[d]));
    check($sformatf("dut%0d timeout", d), 32'(tmo), 32'(et));
  endtask

  task automatic compare_all();
    compare_one(0, 32'(bus0.rst_out), bus0.done, bus0.timeout);
    compare_one(1, 32'(bus1.rst_out), bus1.done, bus1.timeout);
    compare_one(2, 32'(bus2.rst_out), bus2.done, bus2.timeout);
    compare_one(3, 32'(bus3.rst_out), bus3.done, bus3.timeout);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int reset_left;
    model_reset();

    // Power-up: reset held 5 cycles, then ready asserted for a full sequence.
    repeat (5) cycle();
    reset = 1'b0;
    ready_async = 1'b1;
    repeat (80) cycle();

    // Drop ready mid-sequence, then re-raise for a full rerun.
    ready_async = 1'b0;
    repeat (10) cycle();
    ready_async = 1'b1;
    repeat (50) cycle();
    ready_async = 1'b0;
    repeat (6) cycle();
    ready_async = 1'b1;
    repeat (80) cycle();

    // Restart pulse in DONE.
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    repeat (80) cycle();

    // Long HOLD to exercise the watchdog, with a restart to clear it.
    ready_async = 1'b0;
    repeat (15) cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    repeat (12) cycle();

    reset_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (reset_left > 0) begin
        reset_left--;
        if (reset_left == 0) reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        // Asynchronous reset between edges must clear outputs without a clock.
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        reset_left = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 79) == 0) ready_async = ~ready_async;
      restart = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
